// File: rtl/ser_mem_loader_if.sv
// Memory data-port bundle between the serial loader (master) and system memory (slave).
interface ser_mem_loader_if;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_dout_o;
    logic [3:0]  mem_wren_o;
    logic [31:0] mem_din_i;

    modport master (output mem_addr_o, output mem_dout_o, output mem_wren_o, input mem_din_i);
    modport slave  (input mem_addr_o, input mem_dout_o, input mem_wren_o, output mem_din_i);
endinterface

// File: rtl/ser_mem_loader.sv
// UART-driven memory loader: 'W'/'R' word commands from a host drive the memory data port,
// replies go back on TX, and the core is held off while a command is in flight.
module ser_mem_loader #(
    parameter int unsigned CLK_DIV     = 434,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ldr_rxd,
    output logic                    ldr_txd,
    ser_mem_loader_if.master        mem,
    output logic                    hold_o,
    output logic                    busy_o
);
    localparam logic [15:0] BitLast  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);
    localparam logic [31:0] ToLast   = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
    typedef enum logic {TxIdle, TxBusy} tx_st_e;
    typedef enum logic [2:0] {
        StIdle, StGetAddr, StGetData, StMemWr, StMemRd, StMemRdWait, StSend, StSendWait
    } cmd_st_e;

    // ---------------- RX ----------------
    rx_st_e      rx_st_q, rx_st_d;
    logic [2:0]  rx_sync_q;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_line, rx_fall;

    // [1] is the synchronized line, [2] its previous value for edge detection
    assign rx_line = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        unique case (rx_st_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_st_d = RxStart;
            end
            RxStart: if (rx_cnt_q == HalfLast) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_line ? RxIdle : RxData;
            end
            RxData: if (rx_cnt_q == BitLast) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_line, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RxStop;
            end
            RxStop: if (rx_cnt_q == BitLast) begin
                rx_valid_d = rx_line;
                rx_st_d    = RxIdle;
            end
            default: rx_st_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q  <= 3'b111;
            rx_st_q    <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[1:0], ldr_rxd};
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // ---------------- TX ----------------
    tx_st_e      tx_st_q, tx_st_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [9:0]  tx_sh_q, tx_sh_d;
    logic        tx_valid, tx_ready, tx_last;
    logic [7:0]  tx_byte;

    // A byte offered in the final stop-bit cycle starts next cycle, so frames abut
    assign tx_last  = (tx_st_q == TxBusy) && (tx_cnt_q == BitLast) && (tx_bit_q == 4'd9);
    assign tx_ready = (tx_st_q == TxIdle) || tx_last;
    assign ldr_txd  = (tx_st_q == TxBusy) ? tx_sh_q[0] : 1'b1;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        if (tx_st_q == TxBusy) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_cnt_q == BitLast) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 4'd1;
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                if (tx_bit_q == 4'd9) tx_st_d = TxIdle;
            end
        end
        if (tx_valid && tx_ready) begin
            tx_st_d  = TxBusy;
            tx_cnt_d = '0;
            tx_bit_d = '0;
            tx_sh_d  = {1'b1, tx_byte, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q  <= TxIdle;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
        end
    end

    // ---------------- Command FSM ----------------
    cmd_st_e     st_q, st_d;
    logic        wmode_q, wmode_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] reply_q, reply_d;
    logic [2:0]  rcnt_q, rcnt_d;
    logic [31:0] to_q, to_d;

    always_comb begin
        st_d     = st_q;
        wmode_d  = wmode_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        reply_d  = reply_q;
        rcnt_d   = rcnt_q;
        to_d     = '0;
        tx_valid = 1'b0;
        tx_byte  = reply_q[31:24];
        unique case (st_q)
            StIdle: if (rx_valid_q) begin
                bcnt_d = '0;
                if (rx_sh_q == 8'h57) begin
                    wmode_d = 1'b1;
                    st_d    = StGetAddr;
                end else if (rx_sh_q == 8'h52) begin
                    wmode_d = 1'b0;
                    st_d    = StGetAddr;
                end else begin
                    tx_valid = 1'b1;
                    tx_byte  = 8'h3F;
                end
            end
            StGetAddr, StGetData: begin
                to_d = to_q + 32'd1;
                if (rx_valid_q) begin
                    to_d   = '0;
                    word_d = {word_q[15:0], rx_sh_q};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (st_q == StGetAddr) begin
                            addr_d = {word_q, rx_sh_q[7:2], 2'b00};
                            st_d   = wmode_q ? StGetData : StMemRd;
                        end else begin
                            dout_d = {word_q, rx_sh_q};
                            st_d   = StMemWr;
                        end
                    end
                end else if (to_q == ToLast) begin
                    st_d = StIdle;
                end
            end
            StMemWr: begin
                reply_d = {8'h4B, 24'h0};
                rcnt_d  = 3'd1;
                st_d    = StSend;
            end
            StMemRd: st_d = StMemRdWait;
            StMemRdWait: begin
                reply_d = mem.mem_din_i;
                rcnt_d  = 3'd4;
                st_d    = StSend;
            end
            StSend: if (tx_ready) begin
                tx_valid = 1'b1;
                reply_d  = {reply_q[23:0], 8'h0};
                rcnt_d   = rcnt_q - 3'd1;
                st_d     = StSendWait;
            end
            StSendWait: if (tx_last) begin
                if (rcnt_q != 3'd0) begin
                    tx_valid = 1'b1;
                    reply_d  = {reply_q[23:0], 8'h0};
                    rcnt_d   = rcnt_q - 3'd1;
                end else begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            wmode_q <= 1'b0;
            bcnt_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            reply_q <= '0;
            rcnt_q  <= '0;
            to_q    <= '0;
        end else begin
            st_q    <= st_d;
            wmode_q <= wmode_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            reply_q <= reply_d;
            rcnt_q  <= rcnt_d;
            to_q    <= to_d;
        end
    end

    assign mem.mem_addr_o = addr_q;
    assign mem.mem_dout_o = dout_q;
    assign mem.mem_wren_o = (st_q == StMemWr) ? 4'hF : 4'h0;
    assign busy_o         = (st_q != StIdle);
    assign hold_o         = (st_q != StIdle);
endmodule
